// File: rtl/button_digit_selector.sv
// rtl/button_digit_selector.sv - two-button debounced digit selector over four switch nibbles
// Button 0 steps sel up, button 1 steps it down; d tracks the selected nibble of sw.
module button_digit_selector #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_button0,
  input  logic        push_button1,
  input  logic [15:0] sw,
  output logic [1:0]  sel,
  output logic [3:0]  d,
  output logic        sel_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    raw;
  logic [1:0]    sync1, sync2;
  logic [1:0]    db;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  assign raw = {push_button1, push_button0};

  // Per-button synchronizer, debounce counter and registered rising-edge press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      press <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          cnt[i]   <= '0;
          db[i]    <= sync2[i];
          press[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Coincident presses cancel; d samples the old sel so it trails a sel update by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= 2'd0;
      d           <= 4'h0;
      sel_changed <= 1'b0;
    end else begin
      d           <= sw[{sel, 2'b00} +: 4];
      sel_changed <= press[0] ^ press[1];
      case (press)
        2'b01:   sel <= sel + 2'd1;
        2'b10:   sel <= sel - 2'd1;
        default: sel <= sel;
      endcase
    end
  end

endmodule

// File: doc/button_digit_selector.md
BUTTON_DIGIT_SELECTOR -- requirements
Module: button_digit_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000, shall set the consecutive stable cycles a button must hold before its debounced state changes; legal range 2..2^20-1.
REQ-002 clk  input  1  shall be the single clock; all state shall update on its rising edge.
REQ-003 rst_n  input  1  shall be the reset: asynchronous, active-low.
REQ-004 push_button0  input  1  shall be the raw, asynchronous, bouncing "next digit" button, active-high.
REQ-005 push_button1  input  1  shall be the raw, asynchronous, bouncing "previous digit" button, active-high.
REQ-006 sw  input  16  shall carry four hex digits: digit0 = sw[3:0], digit1 = sw[7:4], digit2 = sw[11:8], digit3 = sw[15:12].
REQ-007 sel  output  2  shall be the currently selected digit index, registered.
REQ-008 d  output  4  shall be the selected nibble, registered, for the seven-segment decoder.
REQ-009 sel_changed  output  1  shall be a one-cycle pulse marking a sel update.

Function
REQ-010 Each button shall pass through its own two-flop synchronizer before any other logic.
REQ-011 Each button shall have an independent debounce counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits and a debounced state register.
REQ-012 While the synchronized input equals the debounced state, the counter shall hold 0.
REQ-013 While the synchronized input differs from the debounced state, the counter shall increment by 1 per cycle.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 with the input still differing, the debounced state shall take the input value on that edge, and the counter shall return to 0.
REQ-015 Any cycle in which the input again equals the debounced state before that point shall clear the counter (bounce rejection).
REQ-016 A debounced 0->1 transition shall produce a press pulse exactly one cycle wide; a 1->0 transition shall produce nothing.
REQ-017 Latency from a clean raw rising edge to the press pulse shall be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, fixed and deterministic.
REQ-018 A press on button0 alone shall increment sel modulo 4 (3 -> 0 wraps).
REQ-019 A press on button1 alone shall decrement sel modulo 4 (0 -> 3 wraps).
REQ-020 Press pulses from both buttons in the same cycle shall leave sel unchanged and shall not assert sel_changed.
REQ-021 sel_changed shall assert in the cycle sel takes its new value, for exactly one cycle per accepted press.
REQ-022 A held button shall generate one press only; auto-repeat is excluded.
REQ-023 d shall be registered from the nibble indexed by the current sel every cycle: a sw change appears on d one cycle later, and a sel change appears on d one cycle after sel.
REQ-024 No combinational path shall exist from any input to any output.

Reset
REQ-025 While rst_n = 0: sel = 2'd0, d = 4'h0, sel_changed = 0, all synchronizer flops = 0, debounced states = 0, counters = 0.
REQ-026 Reset assertion shall take effect immediately, without a clock edge, including mid-debounce; a partially counted press shall be discarded.
REQ-027 After rst_n deasserts, a button already held high shall be treated as a new press once it completes the full REQ-017 latency.

Verification (DEBOUNCE_CYCLES = 4 for simulation)
REQ-028 Reset, sw = 16'hA5C3, no presses -> sel = 0, d = 4'h3 from the second edge after reset release, sel_changed never asserts.
REQ-029 Clean button0 press held 20 cycles -> a single sel_changed pulse 7 cycles after the raw edge; sel = 1; d = 4'hC one cycle later.
REQ-030 Button0 bouncing 1,0,1,1,0 at one-cycle intervals, then held high -> no pulse during bounce; exactly one pulse 7 cycles after the final stable rise.
REQ-031 Four button0 presses from sel = 0 -> sel sequence 1, 2, 3, 0 with d following 4'hC, 4'h5, 4'hA, 4'h3. One button1 press from sel = 0 -> sel = 3, d = 4'hA.
REQ-032 Both buttons rise on the same cycle, held -> coincident press pulses, sel unchanged, sel_changed = 0.
REQ-033 rst_n pulsed low 2 cycles into the debounce window of a press -> outputs return to reset values asynchronously; with the button still held after release, one press is accepted 7 cycles after rst_n rises.
